microseq_param: RTL and testbench
=================================

Name: microseq_param

Overview:
- Parametrised successor to the fixed ARMv4 microcode sequencer.
- Each cycle, produces the control-store address for the next microinstruction.
- Sequencing is selected per microinstruction: next, jump, conditional branch on a selectable condition bit, family dispatch, subroutine call/return with a hardware stack, wait-for-memory, and end-of-instruction return to fetch.
- Sits between the instruction decoder (family_number, condition vector) and the control store ROM.

Parameters:
- ADDR_W, 7: control-store address width.
- FAMILY_W, 4: width of family_number.
- DISP_SHIFT, 3: dispatch target = family_number << DISP_SHIFT.
- FETCH_ADDR, 104: first fetch microstate; the reset and end-of-instruction target.
- COND_N, 4: width of cond_vec.
- STACK_DEPTH, 2: microsubroutine return stack entries (1..8).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold the current address.
- family_number  in  FAMILY_W  decoded instruction family.
- cond_pass  in  1  ARM condition-code check result.
- cond_vec  in  COND_N  condition bits: [0]=P/L, [1]=A, [2]=IR_20, [3]=MEM_R.
- uop_mod  in  3  sequencing mode of the current microinstruction.
- uop_cond_sel  in  clog2(COND_N)  index into cond_vec.
- uop_j  in  ADDR_W  jump field J.
- addr  out  ADDR_W  current microstate address.
- at_fetch  out  1  addr == FETCH_ADDR.
- sp  out  clog2(STACK_DEPTH+1)  stack occupancy.
- seq_err  out  1  sticky: stack overflow or underflow.

Behaviour:
- Reset (rst low, asynchronous): addr=FETCH_ADDR, sp=0, seq_err=0, at_fetch=1. Stack contents are don't-care.
- Registered output: addr changes only on the rising edge. A mode applied in cycle n selects addr for cycle n+1.
- Priority: stall > uop_mod. When stall=1, addr, sp and stack are held and no push or pop occurs.
- Address arithmetic: addr+1 wraps modulo 2^ADDR_W.
- Modes:
  - 0 NEXT: addr+1.
  - 1 JUMP: J.
  - 2 BRANCH: cond_vec[uop_cond_sel] ? J : addr+1. A select index >= COND_N reads as 0.
  - 3 DISPATCH: cond_pass ? (family_number << DISP_SHIFT) truncated to ADDR_W : FETCH_ADDR. A failed condition skips the instruction.
  - 4 CALL: push addr+1, then go to J. If the stack is full: no push, seq_err=1, still go to J.
  - 5 RETURN: pop into addr. If the stack is empty: addr=FETCH_ADDR, seq_err=1.
  - 6 FETCH_END: FETCH_ADDR. The stack is not cleared (a nonzero sp here is legal but flagged by assertion in simulation).
  - 7 WAIT: hold addr while cond_vec[3]=0. Once it is 1, go to J.
- Stack is LIFO; sp increments on push and decrements on pop.
- seq_err clears only on reset.
- Dispatch with family_number beyond the address range truncates silently; the control store must not place families there.

Optional Feature:
- USEQ_ABORT_EN defined: adds port abort (in, 1).
  - abort=1 at a rising edge forces addr=FETCH_ADDR and sp=0 on that edge.
  - Priority is above stall but below rst; seq_err is unaffected.
  - Used for the interrupt/exception entry hook.
- USEQ_ABORT_EN undefined: no abort port; behaviour exactly as above.

Test Plan:
- Reset and fetch: release rst with modes NEXT, NEXT, DISPATCH, family_number=3, cond_pass=1 -> addr 104, 105, 106, 24. Asserting rst low mid-sequence -> addr=104 immediately, without waiting for a clock edge.
- Branch select: at addr 24, BRANCH, cond_sel=1, J=27: cond_vec[1]=1 -> 27; cond_vec[1]=0 -> 25. Then FETCH_END -> 104.
- Call/return: at addr 40, CALL J=59 -> addr 59, sp=1. A second CALL J=70 from 59 -> sp=2. RETURN -> 60, sp=1. RETURN -> 41, sp=0. A third RETURN -> 104, seq_err=1.
- Overflow: STACK_DEPTH=2, three consecutive CALLs -> third goes to J, sp stays 2, seq_err=1. Following RETURNs unwind the first two return addresses correctly.
- Wait/stall: WAIT J=45 with cond_vec[3]=0 for 3 cycles -> addr held for 3 cycles, then 45 one edge after cond_vec[3]=1. stall=1 during a CALL -> no push, sp unchanged.
- Condition fail and wrap (ADDR_W=7): DISPATCH with cond_pass=0, family_number=14 -> 104. NEXT at addr 127 -> 0. With USEQ_ABORT_EN, abort together with stall at sp=2 -> 104, sp=0.

Source files
------------

// File: rtl/microseq_param.sv
// Microcode sequencer: registered control-store address with next/jump/branch/dispatch/call/return/wait modes.
// Optional USEQ_ABORT_EN adds an abort input that forces a return to fetch and empties the return stack.
module microseq_param #(
   parameter int ADDR_W      = 7,
   parameter int FAMILY_W    = 4,
   parameter int DISP_SHIFT  = 3,
   parameter int FETCH_ADDR  = 104,
   parameter int COND_N      = 4,
   parameter int STACK_DEPTH = 2,
   localparam int CSW = (COND_N > 1) ? $clog2(COND_N) : 1,
   localparam int SPW = $clog2(STACK_DEPTH + 1),
   localparam int DW  = ADDR_W + FAMILY_W + DISP_SHIFT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
`ifdef USEQ_ABORT_EN
   input  logic                abort,
`endif
   input  logic [FAMILY_W-1:0] family_number,
   input  logic                cond_pass,
   input  logic [COND_N-1:0]   cond_vec,
   input  logic [2:0]          uop_mod,
   input  logic [CSW-1:0]      uop_cond_sel,
   input  logic [ADDR_W-1:0]   uop_j,
   output logic [ADDR_W-1:0]   addr,
   output logic                at_fetch,
   output logic [SPW-1:0]      sp,
   output logic                seq_err
);

   localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);
   localparam logic [SPW-1:0]    FULL  = SPW'(STACK_DEPTH);

   logic [ADDR_W-1:0] addr_q, addr_d, inc, top, disp;
   logic [SPW-1:0]    sp_q, sp_d;
   logic              err_q, err_d, at_fetch_q, push, sel_bit, mem_r;
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

   always_comb begin
      inc     = addr_q + ADDR_W'(1);
      disp    = ADDR_W'(DW'(family_number) << DISP_SHIFT);
      sel_bit = 1'b0;
      mem_r   = 1'b0;
      top     = '0;
      // Out-of-range condition selects fall through as 0.
      for (int i = 0; i < COND_N; i++) begin
         if (CSW'(i) == uop_cond_sel) sel_bit = cond_vec[i];
         if (i == 3) mem_r = cond_vec[i];
      end
      for (int i = 0; i < STACK_DEPTH; i++)
         if (SPW'(i) == sp_q - SPW'(1)) top = stack_q[i];

      addr_d = addr_q;
      sp_d   = sp_q;
      err_d  = err_q;
      push   = 1'b0;
      case (uop_mod)
         3'd0: addr_d = inc;
         3'd1: addr_d = uop_j;
         3'd2: addr_d = sel_bit ? uop_j : inc;
         3'd3: addr_d = cond_pass ? disp : FETCH;
         3'd4: begin
            addr_d = uop_j;
            if (sp_q == FULL) err_d = 1'b1;
            else begin
               push = 1'b1;
               sp_d = sp_q + SPW'(1);
            end
         end
         3'd5: begin
            if (sp_q == '0) begin
               addr_d = FETCH;
               err_d  = 1'b1;
            end else begin
               addr_d = top;
               sp_d   = sp_q - SPW'(1);
            end
         end
         3'd6: addr_d = FETCH;
         default: addr_d = mem_r ? uop_j : addr_q;
      endcase

      if (stall) begin
         addr_d = addr_q;
         sp_d   = sp_q;
         err_d  = err_q;
         push   = 1'b0;
      end
`ifdef USEQ_ABORT_EN
      if (abort) begin
         addr_d = FETCH;
         sp_d   = '0;
         err_d  = err_q;
         push   = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q     <= FETCH;
         sp_q       <= '0;
         err_q      <= 1'b0;
         at_fetch_q <= 1'b1;
      end else begin
         addr_q     <= addr_d;
         sp_q       <= sp_d;
         err_q      <= err_d;
         at_fetch_q <= (addr_d == FETCH);
      end
   end

   // Return stack body needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STACK_DEPTH; i++)
         if (push && SPW'(i) == sp_q) stack_q[i] <= inc;
   end

   assign addr     = addr_q;
   assign at_fetch = at_fetch_q;
   assign sp       = sp_q;
   assign seq_err  = err_q;

`ifndef SYNTHESIS
   fetch_end_empty: assert property (@(posedge clk) disable iff (!rst)
      (!stall && uop_mod == 3'd6) |-> (sp_q == '0))
      else $warning("fetch end with live return stack entries");
`endif

endmodule

// File: tb/tb_microseq_param.sv
// Scoreboard bench for microseq_param: directed scenarios plus random modes checked against a queue-based model.
module tb_microseq_param;
   localparam int ADDR_W = 7, FAMILY_W = 4, DISP_SHIFT = 3, FETCH = 104, COND_N = 4, DEPTH = 2;
   localparam int M = 1 << ADDR_W;

   logic clk = 0, rst = 0, stall = 0, cond_pass = 0;
`ifdef USEQ_ABORT_EN
   logic abort = 0;
`endif
   logic [FAMILY_W-1:0] family_number = '0;
   logic [COND_N-1:0]   cond_vec = '0;
   logic [2:0]          uop_mod = '0;
   logic [1:0]          uop_cond_sel = '0;
   logic [ADDR_W-1:0]   uop_j = '0;
   logic [ADDR_W-1:0]   addr;
   logic                at_fetch, seq_err;
   logic [1:0]          sp;

   microseq_param dut (
      .clk(clk), .rst(rst), .stall(stall),
`ifdef USEQ_ABORT_EN
      .abort(abort),
`endif
      .family_number(family_number), .cond_pass(cond_pass), .cond_vec(cond_vec),
      .uop_mod(uop_mod), .uop_cond_sel(uop_cond_sel), .uop_j(uop_j),
      .addr(addr), .at_fetch(at_fetch), .sp(sp), .seq_err(seq_err));

   always #5 clk = ~clk;

   typedef struct { int a; int sp; bit err; } exp_t;
   exp_t q[$];
   int   checks = 0, errors = 0;

   int   m_addr;
   int   stk[$];
   bit   m_err;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = FETCH;
      stk.delete();
      m_err = 0;
   endtask

   // Caller is at a negedge; drive, predict, return at the next negedge.
   task automatic step(input int mode, input int j = 0, input int sel = 0, input int cv = 0,
                       input bit cp = 0, input int fam = 0, input bit st = 0, input bit ab = 0);
      exp_t e;
      uop_mod = 3'(mode); uop_j = ADDR_W'(j); uop_cond_sel = 2'(sel); cond_vec = COND_N'(cv);
      cond_pass = cp; family_number = FAMILY_W'(fam); stall = st;
`ifdef USEQ_ABORT_EN
      abort = ab;
`endif
      if (ab) begin
         m_addr = FETCH;
         stk.delete();
      end else if (!st) begin
         case (mode)
            0: m_addr = (m_addr + 1) % M;
            1: m_addr = j;
            2: m_addr = (sel < COND_N && cv[sel]) ? j : (m_addr + 1) % M;
            3: m_addr = cp ? (fam * (1 << DISP_SHIFT)) % M : FETCH;
            4: begin
               if (stk.size() == DEPTH) m_err = 1;
               else stk.push_back((m_addr + 1) % M);
               m_addr = j;
            end
            5: begin
               if (stk.size() == 0) begin m_addr = FETCH; m_err = 1; end
               else m_addr = stk.pop_back();
            end
            6: m_addr = FETCH;
            default: if (cv[3]) m_addr = j;
         endcase
      end
      e.a = m_addr; e.sp = stk.size(); e.err = m_err;
      q.push_back(e);
      @(negedge clk);
      stall = 0;
`ifdef USEQ_ABORT_EN
      abort = 0;
`endif
   endtask

   // Async reset applied between edges; outputs must respond before any clock.
   task automatic mid_reset(input string nm);
      @(posedge clk); #3;
      rst = 0;
      #1;
      chk({nm, "_addr"}, int'(addr), FETCH);
      chk({nm, "_at_fetch"}, int'(at_fetch), 1);
      chk({nm, "_sp"}, int'(sp), 0);
      chk({nm, "_err"}, int'(seq_err), 0);
      model_reset();
      @(negedge clk);
      rst = 1;
   endtask

   initial forever begin
      exp_t e;
      @(posedge clk); #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("addr", int'(addr), e.a);
         chk("sp", int'(sp), e.sp);
         chk("seq_err", int'(seq_err), int'(e.err));
         chk("at_fetch", int'(at_fetch), int'(e.a == FETCH));
      end
   end

   initial begin
      int mode;
      model_reset();
      #12;
      chk("rst_addr", int'(addr), FETCH);
      chk("rst_at_fetch", int'(at_fetch), 1);
      chk("rst_sp", int'(sp), 0);
      chk("rst_err", int'(seq_err), 0);
      @(negedge clk);
      rst = 1;
      step(0); step(0); step(3, 0, 0, 0, 1, 3);             // 105, 106, 24
      step(2, 27, 1, 4'b0010);                               // 27
      step(1, 24);
      step(2, 27, 1, 4'b1101);                               // 25
      step(6);                                               // 104
      step(0);
      mid_reset("midrst");

      step(1, 40); step(4, 59); step(4, 70);
      step(5); step(5); step(5);                             // 60, 41, 104+err
      mid_reset("rst2");

      step(4, 10); step(4, 20); step(4, 30);                 // overflow on third
      step(5); step(5);                                      // 21? no: 11, 105

      step(7, 45, 0, 0); step(7, 45, 0, 0); step(7, 45, 0, 0);
      step(7, 45, 0, 4'b1000);                               // 45
      step(4, 90, 0, 0, 0, 0, 1);                            // stalled call
      step(3, 0, 0, 0, 0, 14);                               // 104
      step(1, 127); step(0);                                 // wrap to 0
`ifdef USEQ_ABORT_EN
      step(4, 10); step(4, 20);
      step(0, 0, 0, 0, 0, 0, 1, 1);                          // abort beats stall
`endif

      for (int n = 0; n < 2000; n++) begin
         mode = $urandom_range(0, 7);
         if (mode == 6 && stk.size() != 0) mode = 0;
         step(mode, $urandom_range(0, M - 1), $urandom_range(0, 3), $urandom_range(0, 15),
              1'($urandom_range(0, 1)), $urandom_range(0, 15), ($urandom_range(0, 7) == 0));
      end

      @(posedge clk); #2;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
